// File: rtl/pool2d.sv
// pool2d: streaming PxP non-overlapping pooling (max or floor-average) over
// raster-order frames, NUM_CHANNELS channels in parallel. Partial window
// results live in a horizontal accumulator plus one row-buffer entry per
// output column; the pooled pixel is registered one cycle after the pixel
// that completes its window.
module pool2d #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 6,
  parameter int NUM_COLUMNS  = 28,
  parameter int NUM_ROWS     = 28,
  parameter int POOL_SIZE    = 2,
  parameter int POOL_MODE    = 0
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_valid,
  input  logic signed [DATA_WIDTH*NUM_CHANNELS-1:0] i_features,
  output logic signed [DATA_WIDTH*NUM_CHANNELS-1:0] o_features,
  output logic                                      o_valid,
  output logic                                      o_last
);

  // log2 of the window edge (only 2 and 4 are legal window sizes)
  localparam int PL        = (POOL_SIZE == 4) ? 2 : 1;
  // an average divides by P*P, i.e. shifts right by 2*log2(P)
  localparam int SHIFT     = 2 * PL;
  // accumulator width: a P*P sum of DATA_WIDTH values can never overflow
  localparam int ACC_W     = DATA_WIDTH + SHIFT;
  localparam int OUT_COLS  = NUM_COLUMNS / POOL_SIZE;
  localparam int OUT_ROWS  = NUM_ROWS / POOL_SIZE;
  // columns/rows actually covered by complete windows
  localparam int FULL_COLS = OUT_COLS * POOL_SIZE;
  localparam int FULL_ROWS = OUT_ROWS * POOL_SIZE;
  localparam int CW        = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int RW        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int OC_W      = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int FW        = DATA_WIDTH * NUM_CHANNELS;
  localparam int BW        = ACC_W * NUM_CHANNELS;

  // Sign-extend a sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_f(input logic signed [DATA_WIDTH-1:0] p);
    return {{SHIFT{p[DATA_WIDTH-1]}}, p};
  endfunction

  // Merge two partial window results: signed max, or sum.
  function automatic logic signed [ACC_W-1:0] combine_f(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] r;
    if (POOL_MODE == 1) begin
      r = a + b;
    end else begin
      r = (a > b) ? a : b;
    end
    return r;
  endfunction

  // Turn a complete window result into an output sample; the arithmetic
  // shift floors toward negative infinity.
  function automatic logic signed [DATA_WIDTH-1:0] finalize_f(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    if (POOL_MODE == 1) begin
      t = a >>> SHIFT;
    end else begin
      t = a;
    end
    return DATA_WIDTH'(t);
  endfunction

  logic [CW-1:0]           col_r;
  logic [RW-1:0]           row_r;
  logic signed [ACC_W-1:0] h_acc_r [NUM_CHANNELS];
  logic [BW-1:0]           row_buf_r [OUT_COLS];
  logic                    valid_r;
  logic                    last_r;
  logic [FW-1:0]           feat_r;

  logic signed [ACC_W-1:0] pix_ext_s [NUM_CHANNELS];
  logic signed [ACC_W-1:0] h_new_s [NUM_CHANNELS];
  logic signed [ACC_W-1:0] v_new_s [NUM_CHANNELS];
  logic [BW-1:0]           buf_rd_s;
  logic [BW-1:0]           buf_wr_s;
  logic [FW-1:0]           result_s;
  logic [OC_W-1:0]         oc_s;
  logic                    col_last_s;
  logic                    row_last_s;
  logic                    in_win_s;
  logic                    win_first_col_s;
  logic                    win_last_col_s;
  logic                    win_first_row_s;
  logic                    win_last_row_s;
  logic                    frame_end_s;
  logic                    take_s;
  logic                    out_fire_s;

  // Frame position decode: wrap points, window phase and the output column.
  always_comb begin
    col_last_s      = (col_r == CW'(NUM_COLUMNS - 1));
    row_last_s      = (row_r == RW'(NUM_ROWS - 1));
    in_win_s        = ({1'b0, col_r} < (CW+1)'(FULL_COLS)) &&
                      ({1'b0, row_r} < (RW+1)'(FULL_ROWS));
    win_first_col_s = (col_r[PL-1:0] == {PL{1'b0}});
    win_last_col_s  = (col_r[PL-1:0] == {PL{1'b1}});
    win_first_row_s = (row_r[PL-1:0] == {PL{1'b0}});
    win_last_row_s  = (row_r[PL-1:0] == {PL{1'b1}});
    frame_end_s     = ({1'b0, col_r} == (CW+1)'(FULL_COLS - 1)) &&
                      ({1'b0, row_r} == (RW+1)'(FULL_ROWS - 1));
    oc_s            = OC_W'(col_r >> PL);
    // a pixel asserted together with reset is dropped
    take_s          = i_valid && !i_rst && in_win_s;
    out_fire_s      = take_s && win_last_col_s && win_last_row_s;
  end

  // Per-channel datapath: the first column/row of a window loads, later ones merge.
  always_comb begin
    buf_rd_s = row_buf_r[oc_s];
    buf_wr_s = {BW{1'b0}};
    result_s = {FW{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pix_ext_s[c] = sext_f(i_features[c*DATA_WIDTH +: DATA_WIDTH]);
      if (win_first_col_s) begin
        h_new_s[c] = pix_ext_s[c];
      end else begin
        h_new_s[c] = combine_f(h_acc_r[c], pix_ext_s[c]);
      end
      if (win_first_row_s) begin
        v_new_s[c] = h_new_s[c];
      end else begin
        v_new_s[c] = combine_f(buf_rd_s[c*ACC_W +: ACC_W], h_new_s[c]);
      end
      buf_wr_s[c*ACC_W +: ACC_W]         = v_new_s[c];
      result_s[c*DATA_WIDTH +: DATA_WIDTH] = finalize_f(v_new_s[c]);
    end
  end

  // Column/row counters advance on qualified pixels only and wrap at frame end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (i_valid) begin
      if (col_last_s) begin
        col_r <= {CW{1'b0}};
        if (row_last_s) begin
          row_r <= {RW{1'b0}};
        end else begin
          row_r <= row_r + RW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Partial window storage; stale contents are overwritten by the window-start load rule.
  always_ff @(posedge i_clk) begin
    if (take_s) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        h_acc_r[c] <= h_new_s[c];
      end
      if (win_last_col_s) begin
        row_buf_r[oc_s] <= buf_wr_s;
      end
    end
  end

  // Registered output: one-cycle valid pulse, last flag, features held between pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      feat_r  <= {FW{1'b0}};
    end else begin
      valid_r <= out_fire_s;
      last_r  <= out_fire_s && frame_end_s;
      if (out_fire_s) begin
        feat_r <= result_s;
      end
    end
  end

  assign o_valid    = valid_r;
  assign o_last     = last_r;
  assign o_features = feat_r;

endmodule
